// File: rtl/risk_detection_unit_pkg.sv
// Shared definitions for the pipeline hazard detector: FSM encoding and
// register-file constants.
package risk_detection_unit_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_e;

  localparam logic [REG_ADDR_W_DEF-1:0] ZERO_REG = '0;

endpackage

// File: rtl/risk_detection_unit_risk_compare.sv
// Combinational register comparators that produce the load-use and
// branch-operand hazard terms against the EX and MEM stages.
module risk_compare
  import risk_detection_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_rt,
  input  logic                  i_uses_rt,
  input  logic                  i_branch,
  input  logic                  i_nbranch,
  input  logic                  i_jalr,
  input  logic                  i_ex_memread,
  input  logic                  i_ex_regwrite,
  input  logic [REG_ADDR_W-1:0] i_ex_wreg,
  input  logic                  i_mem_memread,
  input  logic [REG_ADDR_W-1:0] i_mem_wreg,
  output logic                  o_load_use,
  output logic                  o_br_ex,
  output logic                  o_br_mem
);

  localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(ZERO_REG);

  logic w_ex_nz;
  logic w_mem_nz;
  logic w_br;
  logic w_br_uses_rt;
  logic w_ex_hits_rs;
  logic w_ex_hits_rt;
  logic w_mem_hits_rs;
  logic w_mem_hits_rt;

  // $zero is hardwired, so a write to it can never create a dependency.
  assign w_ex_nz       = (i_ex_wreg != ZERO);
  assign w_mem_nz      = (i_mem_wreg != ZERO);
  assign w_br          = i_branch | i_nbranch | i_jalr;
  assign w_br_uses_rt  = i_branch | i_nbranch;

  assign w_ex_hits_rs  = (i_ex_wreg == i_rs);
  assign w_ex_hits_rt  = (i_ex_wreg == i_rt);
  assign w_mem_hits_rs = (i_mem_wreg == i_rs);
  assign w_mem_hits_rt = (i_mem_wreg == i_rt);

  assign o_load_use = i_ex_memread & w_ex_nz
                    & (w_ex_hits_rs | (i_uses_rt & w_ex_hits_rt));
  assign o_br_ex    = w_br & i_ex_regwrite & w_ex_nz
                    & (w_ex_hits_rs | (w_br_uses_rt & w_ex_hits_rt));
  assign o_br_mem   = w_br & i_mem_memread & w_mem_nz
                    & (w_mem_hits_rs | (w_br_uses_rt & w_mem_hits_rt));

endmodule

// File: rtl/risk_detection_unit.sv
// Hazard detection unit: stall/flush control for the 5-stage core, HALT
// drain sequencer and a saturating stall-cycle counter for debug.
module risk_detection_unit
  import risk_detection_unit_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [REG_ADDR_W-1:0] i_ID_rs,
  input  logic [REG_ADDR_W-1:0] i_ID_rt,
  input  logic                  i_ID_UsesRt,
  input  logic                  i_ID_Branch,
  input  logic                  i_ID_NBranch,
  input  logic                  i_ID_JALR,
  input  logic                  i_ID_HALT,
  input  logic                  i_TakeJump,
  input  logic                  i_EX_MemRead,
  input  logic                  i_EX_RegWrite,
  input  logic [REG_ADDR_W-1:0] i_EX_WriteReg,
  input  logic                  i_MEM_MemRead,
  input  logic [REG_ADDR_W-1:0] i_MEM_WriteReg,
  output logic                  o_Risk,
  output logic                  o_PCWrite,
  output logic                  o_IFIDWrite,
  output logic                  o_IFIDFlush,
  output logic                  o_Halted,
  output logic [CNT_W-1:0]      o_StallCount
);

  localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [DCNT_W-1:0]  r_dcnt;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               r_halted;

  logic w_load_use;
  logic w_br_ex;
  logic w_br_mem;
  logic w_stall;
  logic w_halt_go;

  risk_compare #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_risk_compare (
    .i_rs          (i_ID_rs),
    .i_rt          (i_ID_rt),
    .i_uses_rt     (i_ID_UsesRt),
    .i_branch      (i_ID_Branch),
    .i_nbranch     (i_ID_NBranch),
    .i_jalr        (i_ID_JALR),
    .i_ex_memread  (i_EX_MemRead),
    .i_ex_regwrite (i_EX_RegWrite),
    .i_ex_wreg     (i_EX_WriteReg),
    .i_mem_memread (i_MEM_MemRead),
    .i_mem_wreg    (i_MEM_WriteReg),
    .o_load_use    (w_load_use),
    .o_br_ex       (w_br_ex),
    .o_br_mem      (w_br_mem)
  );

  assign w_stall   = w_load_use | w_br_ex | w_br_mem;
  // A HALT held back by a hazard only launches once the hazard clears.
  assign w_halt_go = i_ID_HALT & ~w_stall;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    w_state_nxt = r_state;
    o_Risk      = 1'b1;
    o_PCWrite   = 1'b0;
    o_IFIDWrite = 1'b0;
    o_IFIDFlush = 1'b0;
    if (!i_reset) begin
      case (r_state)
        RUN: begin
          o_Risk      = w_stall;
          o_PCWrite   = ~w_stall & ~w_halt_go;
          o_IFIDWrite = ~w_stall & ~w_halt_go;
          o_IFIDFlush = i_TakeJump & ~w_stall;
          if (i_enable && w_halt_go) w_state_nxt = DRAIN;
        end
        DRAIN: begin
          if (i_enable && r_dcnt == DRAIN_LAST) w_state_nxt = HALTED;
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= RUN;
      r_dcnt      <= '0;
      r_stall_cnt <= '0;
      r_halted    <= 1'b0;
    end else if (i_enable) begin
      r_state <= w_state_nxt;
      if (r_state == RUN) begin
        r_dcnt <= '0;
      end else if (r_state == DRAIN && r_dcnt != DRAIN_LAST) begin
        r_dcnt <= r_dcnt + 1'b1;
      end
      if (r_state == RUN && w_stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_state_nxt == HALTED) r_halted <= 1'b1;
    end
  end

  assign o_Halted     = r_halted;
  assign o_StallCount = r_stall_cnt;

endmodule

// File: doc/risk_detection_unit.md
Name: risk_detection_unit

Overview:
- Pipeline hazard detector for the 5-stage MIPS core. It generates the i_Risk bubble request consumed by the control-signal hazard mux, plus the PC and IF/ID write enables and the IF/ID flush.
- Detects load-use and branch-operand hazards against instructions in EX/MEM.
- Handles control-transfer flushes.
- Sequences a HALT drain (RUN -> DRAIN -> HALTED) and keeps a saturating stall-cycle counter for the debug unit.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- DRAIN_CYCLES, 3, cycles spent in DRAIN before HALTED (HALT passing EX, MEM, WB).
- CNT_W, 32, stall counter width.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous active-high reset.
- i_enable  in  1  debug step enable; 0 freezes FSM and counter.
- i_ID_rs  in  REG_ADDR_W  rs of instruction in ID.
- i_ID_rt  in  REG_ADDR_W  rt of instruction in ID.
- i_ID_UsesRt  in  1  ID instruction reads rt as a source.
- i_ID_Branch  in  1  BEQ in ID (resolved in ID).
- i_ID_NBranch  in  1  BNE in ID.
- i_ID_JALR  in  1  JR/JALR in ID (reads rs).
- i_ID_HALT  in  1  HALT in ID.
- i_TakeJump  in  1  branch taken or J/JAL/JALR resolved in ID this cycle.
- i_EX_MemRead  in  1  load in EX.
- i_EX_RegWrite  in  1  EX instruction writes a register.
- i_EX_WriteReg  in  REG_ADDR_W  EX destination register (post RegDst/JAL mux).
- i_MEM_MemRead  in  1  load in MEM.
- i_MEM_WriteReg  in  REG_ADDR_W  MEM destination register.
- o_Risk  out  1  bubble request to control-signal hazard mux.
- o_PCWrite  out  1  PC update enable.
- o_IFIDWrite  out  1  IF/ID register enable.
- o_IFIDFlush  out  1  clear IF/ID (squash fetched instruction).
- o_Halted  out  1  pipeline fully drained after HALT; sticky.
- o_StallCount  out  CNT_W  stall cycles counted.

Behaviour:
- Reset is asynchronous, active-high.
  - While i_reset=1: FSM=RUN, drain counter=0, o_StallCount=0, o_Halted=0.
  - Comb outputs forced to o_Risk=1, o_PCWrite=0, o_IFIDWrite=0, o_IFIDFlush=0.
  - Reset mid-DRAIN or in HALTED returns to RUN immediately.
- Register 0 never matches as a hazard source.
- Hazard terms (combinational):
  - load_use = i_EX_MemRead & EX_WriteReg!=0 & (EX_WriteReg==ID_rs | (ID_UsesRt & EX_WriteReg==ID_rt)).
  - br = Branch|NBranch|JALR. Branch sources are rs, plus rt for Branch/NBranch only.
  - br_ex = br & i_EX_RegWrite & EX_WriteReg!=0 & matches a branch source.
  - br_mem = br & i_MEM_MemRead & MEM_WriteReg!=0 & matches a branch source.
  - stall = load_use | br_ex | br_mem.
- RUN state outputs:
  - o_Risk=stall, o_PCWrite=~stall, o_IFIDWrite=~stall.
  - o_IFIDFlush = i_TakeJump & ~stall; a stalled branch never flushes.
- RUN -> DRAIN on a clock edge with i_enable & i_ID_HALT & ~stall.
  - In that cycle o_Risk=0, so HALT enters ID/EX.
  - o_PCWrite=0 and o_IFIDWrite=0 already in that cycle.
- DRAIN state:
  - o_Risk=1, o_PCWrite=0, o_IFIDWrite=0, o_IFIDFlush=0.
  - Counter increments per enabled cycle.
  - -> HALTED when counter reaches DRAIN_CYCLES-1 on an enabled edge.
- HALTED state:
  - o_Halted=1 (registered, asserted the cycle after the last DRAIN cycle).
  - Same freeze outputs as DRAIN; stays until reset.
- o_StallCount increments on enabled edges when in RUN with stall=1; saturates at all-ones. DRAIN/HALTED cycles are not counted.
- i_enable=0:
  - Comb outputs still evaluated from inputs.
  - FSM, drain counter and o_StallCount hold.
- Priority: reset > HALTED/DRAIN freeze > stall > flush. A HALT in ID under stall waits until the stall clears.

Decomposition:
- Shared package holds:
  - state encoding localparams RUN=2'b00, DRAIN=2'b01, HALTED=2'b10;
  - REG_ADDR_W default;
  - the ZERO_REG constant.
- One natural sub-module: risk_compare. It is purely combinational: given source regs, use flags and EX/MEM dest info, it returns load_use, br_ex, br_mem.
- The FSM and counter live in the top.

Test Plan:
- Load-use: EX lw $t0=8, MemRead=1; ID add rs=8 -> o_Risk=1, o_PCWrite=0, o_IFIDWrite=0 for 1 cycle; o_StallCount 0->1.
- Branch operands: ID beq rs=3 rt=4 with EX RegWrite WriteReg=4 -> stall 1 cycle. Next cycle the same instruction sits in MEM with MemRead=1, WriteReg=4 -> stall again. Total stall count = 2.
- Zero register and flush: EX lw WriteReg=0 with ID rs=0 -> no stall. Then i_TakeJump=1 with no hazard -> o_IFIDFlush=1. With i_TakeJump=1 and br_ex=1 -> o_IFIDFlush=0, o_Risk=1.
- HALT drain: i_ID_HALT=1 with no hazard -> that cycle o_Risk=0, o_PCWrite=0. Then 3 cycles of o_Risk=1, then o_Halted=1, held for 10 more cycles.
- Step/freeze: i_enable=0 during a load-use -> o_Risk=1 but o_StallCount unchanged. Also i_enable=0 mid-DRAIN -> counter holds, o_Halted is delayed by the frozen cycles.
- Async reset: assert i_reset mid-DRAIN, between clock edges -> o_Risk=1, o_PCWrite=0, o_Halted=0, o_StallCount=0 immediately. After deassertion, state is RUN.
